// File: rtl/ft_pkg.sv
// Shared definitions for the fault-tolerance recovery path: FSM encodings and
// the safe-memory layout constants also used by the safe memory's address decode.
package ft_pkg;

   localparam logic [31:0] FT_BASE_ADDR = 32'h0000_0000;
   localparam logic [31:0] FT_PC_OFFSET = 32'h0000_0080;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP,
      ST_WRITE,
      ST_PC_REQ,
      ST_PC_RESP,
      ST_DONE,
      ST_ABORT
   } rec_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_REQ,
      PH_RESP
   } port_phase_e;

endpackage

// File: rtl/ft_obi_read_port.sv
// Single-outstanding OBI read master: holds req/addr until grant, times out
// stalled phases and retries failed attempts, reporting ok/retry/abort per word.
module ft_obi_read_port
   import ft_pkg::*;
#(
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start,
   input  logic [31:0] start_addr,
   input  logic        gnt,
   input  logic        rvalid,
   input  logic        err,
   input  logic [31:0] rdata,
   output logic        req,
   output logic [31:0] addr,
   output logic        granted,
   output logic        word_ok,
   output logic        word_retry,
   output logic        word_abort,
   output logic [31:0] data
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

   port_phase_e      phase;
   logic [TMO_W-1:0] tmo_q;
   logic [RTY_W-1:0] retry_q;
   logic             tmo_sat;
   logic             attempt_fail;

   assign tmo_sat      = (tmo_q == TMO_MAX);
   assign granted      = (phase == PH_REQ) && gnt;
   assign word_ok      = (phase == PH_RESP) && rvalid && !err;
   assign attempt_fail = ((phase == PH_REQ) && !gnt && tmo_sat) ||
                         ((phase == PH_RESP) && (rvalid ? err : tmo_sat));
   assign word_abort   = attempt_fail && (retry_q == RTY_MAX);
   assign word_retry   = attempt_fail && (retry_q != RTY_MAX);
   assign data         = rdata;

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values; blocking ones would create ordering races.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase   <= PH_IDLE;
         req     <= 1'b0;
         addr    <= '0;
         tmo_q   <= '0;
         retry_q <= '0;
      end else if (start && phase == PH_IDLE) begin
         phase   <= PH_REQ;
         req     <= 1'b1;
         addr    <= start_addr;
         tmo_q   <= '0;
         retry_q <= '0;
      end else if (attempt_fail) begin
         tmo_q <= '0;
         if (retry_q == RTY_MAX) begin
            phase <= PH_IDLE;
            req   <= 1'b0;
         end else begin
            retry_q <= retry_q + RTY_W'(1);
            phase   <= PH_REQ;
            req     <= 1'b1;
         end
      end else if (granted) begin
         phase <= PH_RESP;
         req   <= 1'b0;
         tmo_q <= '0;
      end else if (word_ok) begin
         phase <= PH_IDLE;
         tmo_q <= '0;
      end else if (phase != PH_IDLE) begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end

endmodule

// File: rtl/ft_recovery_reader.sv
// Recovery sequencer: reads checkpointed x1..x(NUM_REGS-1) and PC from safe
// memory through the read port, writes the register file, then presents the PC.
module ft_recovery_reader
   import ft_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = FT_BASE_ADDR,
   parameter int          NUM_REGS  = 32,
   parameter logic [31:0] PC_OFFSET = FT_PC_OFFSET,
   parameter int          MAX_RETRY = 3,
   parameter int          TIMEOUT   = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        recover_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic [31:0] data_rdata_i,
   input  logic        data_err_i,
   output logic        rf_we_o,
   output logic [4:0]  rf_addr_o,
   output logic [31:0] rf_wdata_o,
   output logic [31:0] pc_o,
   output logic        pc_set_o
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

   rec_state_e  state;
   logic [4:0]  idx;
   logic        last_reg;
   logic        port_start;
   logic [31:0] port_addr;
   logic [31:0] port_data;
   logic        granted, word_ok, word_retry, word_abort;

   assign data_we_o    = 1'b0;
   assign data_be_o    = 4'hF;
   assign data_wdata_o = '0;
   assign busy_o       = (state != ST_IDLE);
   assign last_reg     = (idx == LAST_IDX);
   assign port_start   = (state == ST_IDLE && recover_i) || (state == ST_WRITE);

   // NOTE: default first, so no path through this block leaves port_addr
   // unassigned and no latch is inferred.
   always_comb begin
      port_addr = BASE_ADDR + 32'd4;
      if (state == ST_WRITE)
         port_addr = last_reg ? BASE_ADDR + PC_OFFSET
                              : BASE_ADDR + {25'd0, idx + 5'd1, 2'b00};
   end

   ft_obi_read_port #(
      .MAX_RETRY (MAX_RETRY),
      .TIMEOUT   (TIMEOUT)
   ) u_port (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start      (port_start),
      .start_addr (port_addr),
      .gnt        (data_gnt_i),
      .rvalid     (data_rvalid_i),
      .err        (data_err_i),
      .rdata      (data_rdata_i),
      .req        (data_req_o),
      .addr       (data_addr_o),
      .granted    (granted),
      .word_ok    (word_ok),
      .word_retry (word_retry),
      .word_abort (word_abort),
      .data       (port_data)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= ST_IDLE;
         idx        <= 5'd1;
         error_o    <= 1'b0;
         done_o     <= 1'b0;
         rf_we_o    <= 1'b0;
         rf_addr_o  <= '0;
         rf_wdata_o <= '0;
         pc_o       <= '0;
         pc_set_o   <= 1'b0;
      end else begin
         // Strobes are single-cycle; they are re-raised only on the transition.
         rf_we_o  <= 1'b0;
         pc_set_o <= 1'b0;
         done_o   <= 1'b0;
         case (state)
            ST_IDLE: if (recover_i) begin
               state   <= ST_REQ;
               idx     <= 5'd1;
               error_o <= 1'b0;
            end
            ST_REQ: begin
               if (word_abort)   state <= ST_ABORT;
               else if (granted) state <= ST_RESP;
            end
            ST_RESP: begin
               if (word_abort)      state <= ST_ABORT;
               else if (word_retry) state <= ST_REQ;
               else if (word_ok) begin
                  state      <= ST_WRITE;
                  rf_we_o    <= 1'b1;
                  rf_addr_o  <= idx;
                  rf_wdata_o <= port_data;
               end
            end
            ST_WRITE: begin
               if (last_reg) state <= ST_PC_REQ;
               else begin
                  idx   <= idx + 5'd1;
                  state <= ST_REQ;
               end
            end
            ST_PC_REQ: begin
               if (word_abort)   state <= ST_ABORT;
               else if (granted) state <= ST_PC_RESP;
            end
            ST_PC_RESP: begin
               if (word_abort)      state <= ST_ABORT;
               else if (word_retry) state <= ST_PC_REQ;
               else if (word_ok) begin
                  state    <= ST_DONE;
                  pc_o     <= port_data;
                  pc_set_o <= 1'b1;
                  done_o   <= 1'b1;
               end
            end
            ST_DONE:  state <= ST_IDLE;
            ST_ABORT: begin
               error_o <= 1'b1;
               state   <= ST_IDLE;
            end
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule
